// File: rtl/facto_job_ctrl_pkg.sv
// Shared constants and types for the facto job controller and its command FIFO.
package facto_job_ctrl_pkg;

  localparam int unsigned W = 8;
  localparam int unsigned FACTO_OVF_LIMIT = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StIssue = ST_ISSUE,
    StWait  = ST_WAIT,
    StHold  = ST_HOLD
  } state_e;

  typedef struct packed {
    logic [W-1:0] fi;
    logic [W-1:0] x;
    logic         ovf;
    logic         tmo;
  } result_t;

  // Factorials above 5! no longer fit in W bits.
  function automatic logic is_ovf(input logic [W-1:0] x);
    return x > W'(FACTO_OVF_LIMIT);
  endfunction

endpackage

// File: rtl/facto_cmd_fifo.sv
// Command FIFO: DEPTH x W entries, async active-low reset, push/pop guarded by full/empty.
module facto_cmd_fifo
  import facto_job_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [W-1:0]    wdata_i,
  input  logic            pop_i,
  output logic [W-1:0]    rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/facto_job_ctrl.sv
// Upstream command stage for the facto core: queues operands, runs one job at a time,
// and returns the result (with echo, overflow and timeout flags) over valid/ready.
module facto_job_ctrl
  import facto_job_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  input  logic [W-1:0] in_x,
  output logic         in_ready,
  output logic         start_o,
  output logic [W-1:0] x_o,
  input  logic         done_i,
  input  logic [W-1:0] fi_i,
  output logic         out_valid,
  output logic [W-1:0] out_fi,
  output logic [W-1:0] out_x,
  output logic         out_ovf,
  output logic         out_tmo,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e          state_q, state_d;
  logic [7:0]      timer_q, timer_d;
  logic [W-1:0]    x_q, x_d;
  result_t         res_q, res_d;
  logic            out_valid_q, out_valid_d;
  logic            done_prev_q;
  logic            rdy_q;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]    fifo_rdata;
  logic [CntW-1:0] fifo_cnt;
  logic            done_rise;
  logic [8:0]      timer_nxt;
  logic            tmo_hit;

  // rdy_q keeps in_ready low until the first clock after reset release.
  assign in_ready  = rdy_q & ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  facto_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (fifo_push),
    .wdata_i (in_x),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign done_rise = done_i & ~done_prev_q;
  assign timer_nxt = {1'b0, timer_q} + 9'd1;
  assign tmo_hit   = (timer_nxt >= 9'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    x_d         = x_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          x_d      = fifo_rdata;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // A completion edge in the same cycle as the timeout takes priority.
        if (done_rise) begin
          res_d       = '{fi: fi_i, x: x_q, ovf: is_ovf(x_q), tmo: 1'b0};
          out_valid_d = 1'b1;
          state_d     = StHold;
        end else if (tmo_hit) begin
          res_d       = '{fi: '0, x: x_q, ovf: is_ovf(x_q), tmo: 1'b1};
          out_valid_d = 1'b1;
          state_d     = StHold;
        end else if (timer_q != 8'hff) begin
          timer_d = timer_nxt[7:0];
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      x_q         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      done_prev_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      x_q         <= x_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      done_prev_q <= done_i;
      rdy_q       <= 1'b1;
    end
  end

  assign start_o   = (state_q == StIssue);
  assign x_o       = x_q;
  assign out_valid = out_valid_q;
  assign out_fi    = res_q.fi;
  assign out_x     = res_q.x;
  assign out_ovf   = res_q.ovf;
  assign out_tmo   = res_q.tmo;
  assign busy      = (state_q != StIdle) | (fifo_cnt != '0);

endmodule
